mapper_savestate_sequencer: RTL and testbench

- Sequences the mapper savestate bus (SaveStateBus_*) for the active mapper.
- Save: walks SS_COUNT register slots from SS_BASE, reads each 64-bit slot, writes it to an external savestate memory through a req/ack port.
- Load: reads slots back from memory, writes each onto the bus, then pulses the bus load strobe so mappers commit SS_MAP* contents into live registers.
- Sits between the savestate manager and the per-mapper eReg_SavestateV instances.

---
 rtl/mapper_savestate_sequencer.sv | 229 ++++++++++++++++++++++
 tb/tb_mapper_savestate_sequencer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mapper_savestate_sequencer.sv
// Savestate bus sequencer: saves mapper slots to external memory and loads them back.
// Optional `SS_CHECKSUM_EN appends an XOR checksum word and gates the commit strobe on it.
module mapper_savestate_sequencer #(
  parameter logic [9:0]  SS_BASE  = 10'd32,
  parameter int unsigned SS_COUNT = 4,
  parameter int unsigned MEM_AW   = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start_save,
  input  logic              start_load,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [9:0]        SaveStateBus_Adr,
  output logic [63:0]       SaveStateBus_Din,
  output logic              SaveStateBus_wren,
  output logic              SaveStateBus_rst,
  output logic              SaveStateBus_load,
  input  logic [63:0]       SaveStateBus_Dout,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [63:0]       mem_wdata,
  output logic              mem_we,
  output logic              mem_req,
  input  logic              mem_ack,
  input  logic [63:0]       mem_rdata
);

  localparam int unsigned IW = 7;
  localparam logic [IW-1:0] LAST = IW'(SS_COUNT - 1);

  localparam logic [3:0] S_IDLE        = 4'd0;
  localparam logic [3:0] S_SAVE_ADR    = 4'd1;
  localparam logic [3:0] S_SAVE_CAP    = 4'd2;
  localparam logic [3:0] S_SAVE_MEM    = 4'd3;
  localparam logic [3:0] S_LOAD_MEM    = 4'd4;
  localparam logic [3:0] S_LOAD_WR     = 4'd5;
  localparam logic [3:0] S_LOAD_COMMIT = 4'd6;
  localparam logic [3:0] S_FINISH      = 4'd7;
`ifdef SS_CHECKSUM_EN
  localparam logic [3:0] S_SAVE_SUM    = 4'd8;
  localparam logic [3:0] S_SAVE_SUMW   = 4'd9;
  localparam logic [3:0] S_LOAD_SUM    = 4'd10;
  localparam logic [3:0] S_LOAD_SUMW   = 4'd11;
`endif

  logic [3:0]        r_state;
  logic [IW-1:0]     r_idx;
  logic              r_busy;
  logic              r_done;
  logic [9:0]        r_adr;
  logic [63:0]       r_din;
  logic              r_wren;
  logic              r_load;
  logic [MEM_AW-1:0] r_mem_addr;
  logic [63:0]       r_mem_wdata;
  logic              r_mem_we;
  logic              r_mem_req;
`ifdef SS_CHECKSUM_EN
  logic              r_err;
  logic [63:0]       r_csum;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_adr       <= '0;
      r_din       <= '0;
      r_wren      <= 1'b0;
      r_load      <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_we    <= 1'b0;
      r_mem_req   <= 1'b0;
`ifdef SS_CHECKSUM_EN
      r_err       <= 1'b0;
      r_csum      <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start_save || start_load) begin
            r_busy <= 1'b1;
            r_idx  <= '0;
`ifdef SS_CHECKSUM_EN
            r_err  <= 1'b0;
            r_csum <= '0;
`endif
            if (start_save) begin
              r_adr   <= SS_BASE;
              r_state <= S_SAVE_ADR;
            end else begin
              r_mem_addr <= '0;
              r_mem_we   <= 1'b0;
              r_mem_req  <= 1'b1;
              r_state    <= S_LOAD_MEM;
            end
          end
        end
        S_SAVE_ADR: r_state <= S_SAVE_CAP;
        S_SAVE_CAP: begin
          r_mem_wdata <= SaveStateBus_Dout;
          r_mem_addr  <= MEM_AW'(r_idx);
          r_mem_we    <= 1'b1;
          r_mem_req   <= 1'b1;
`ifdef SS_CHECKSUM_EN
          r_csum      <= r_csum ^ SaveStateBus_Dout;
`endif
          r_state     <= S_SAVE_MEM;
        end
        S_SAVE_MEM: begin
          if (mem_ack) begin
            r_mem_req <= 1'b0;
            if (r_idx == LAST) begin
`ifdef SS_CHECKSUM_EN
              r_state <= S_SAVE_SUM;
`else
              r_done  <= 1'b1;
              r_state <= S_FINISH;
`endif
            end else begin
              r_idx   <= r_idx + 1'b1;
              r_adr   <= SS_BASE + 10'(r_idx) + 10'd1;
              r_state <= S_SAVE_ADR;
            end
          end
        end
        S_LOAD_MEM: begin
          if (mem_ack) begin
            r_mem_req <= 1'b0;
            r_din     <= mem_rdata;
`ifdef SS_CHECKSUM_EN
            r_csum    <= r_csum ^ mem_rdata;
`endif
            r_adr     <= SS_BASE + 10'(r_idx);
            r_wren    <= 1'b1;
            r_state   <= S_LOAD_WR;
          end
        end
        S_LOAD_WR: begin
          r_wren <= 1'b0;
          if (r_idx == LAST) begin
`ifdef SS_CHECKSUM_EN
            r_state <= S_LOAD_SUM;
`else
            r_load  <= 1'b1;
            r_state <= S_LOAD_COMMIT;
`endif
          end else begin
            r_idx      <= r_idx + 1'b1;
            r_mem_addr <= MEM_AW'(r_idx + 1'b1);
            r_mem_we   <= 1'b0;
            r_mem_req  <= 1'b1;
            r_state    <= S_LOAD_MEM;
          end
        end
`ifdef SS_CHECKSUM_EN
        S_SAVE_SUM: begin
          r_mem_wdata <= r_csum;
          r_mem_addr  <= MEM_AW'(SS_COUNT);
          r_mem_we    <= 1'b1;
          r_mem_req   <= 1'b1;
          r_state     <= S_SAVE_SUMW;
        end
        S_SAVE_SUMW: begin
          if (mem_ack) begin
            r_mem_req <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= S_FINISH;
          end
        end
        S_LOAD_SUM: begin
          r_mem_addr <= MEM_AW'(SS_COUNT);
          r_mem_we   <= 1'b0;
          r_mem_req  <= 1'b1;
          r_state    <= S_LOAD_SUMW;
        end
        S_LOAD_SUMW: begin
          // A bad checksum skips the commit so mapper live registers stay untouched
          if (mem_ack) begin
            r_mem_req <= 1'b0;
            if (mem_rdata != r_csum) begin
              r_err   <= 1'b1;
              r_done  <= 1'b1;
              r_state <= S_FINISH;
            end else begin
              r_load  <= 1'b1;
              r_state <= S_LOAD_COMMIT;
            end
          end
        end
`endif
        S_LOAD_COMMIT: begin
          r_load  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_FINISH;
        end
        S_FINISH: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy              = r_busy;
  assign done              = r_done;
`ifdef SS_CHECKSUM_EN
  assign error             = r_err;
`else
  assign error             = 1'b0;
`endif
  assign SaveStateBus_Adr  = r_adr;
  assign SaveStateBus_Din  = r_din;
  assign SaveStateBus_wren = r_wren;
  assign SaveStateBus_rst  = 1'b0;
  assign SaveStateBus_load = r_load;
  assign mem_addr          = r_mem_addr;
  assign mem_wdata         = r_mem_wdata;
  assign mem_we            = r_mem_we;
  assign mem_req           = r_mem_req;

endmodule

// File: tb/tb_mapper_savestate_sequencer.sv
// Bench for mapper_savestate_sequencer: vector table, random ops against a slot-level model,
// and hand sequences for arbitration, mid-operation reset and (with SS_CHECKSUM_EN) checksum errors.
module tb_mapper_savestate_sequencer;

  localparam int N = 4;
  localparam logic [9:0] BASE = 10'd32;
`ifdef SS_CHECKSUM_EN
  localparam int CS = 2;
  localparam int CSW = 1;
`else
  localparam int CS = 0;
  localparam int CSW = 0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start_save = 1'b0;
  logic        start_load = 1'b0;
  logic        busy, done, error;
  logic [9:0]  Adr;
  logic [63:0] Din, Dout;
  logic        wren, ss_rst, ss_load;
  logic [7:0]  mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_we, mem_req;
  logic        mem_ack = 1'b0;
  logic [63:0] mem_rdata = '0;

  mapper_savestate_sequencer #(.SS_BASE(BASE), .SS_COUNT(N), .MEM_AW(8)) dut (
    .clk(clk), .reset_n(reset_n), .start_save(start_save), .start_load(start_load),
    .busy(busy), .done(done), .error(error),
    .SaveStateBus_Adr(Adr), .SaveStateBus_Din(Din), .SaveStateBus_wren(wren),
    .SaveStateBus_rst(ss_rst), .SaveStateBus_load(ss_load), .SaveStateBus_Dout(Dout),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_req(mem_req),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  logic [63:0] regs [N];
  logic [63:0] mem [256];
  int dly_addr = -1, dly_n = 0;
  int n_wr, n_rd, n_load, bad_load, n_rst, unstable, wcnt;
  logic [9:0]  wq_adr [$];
  logic [63:0] wq_din [$];
  logic [7:0]  f_addr;
  logic [63:0] f_wdata;
  logic        f_we;
  int n_cmp = 0, n_fail = 0;

  // Mapper slots answer the bus address combinationally
  always_comb begin
    int k;
    k = int'(Adr) - int'(BASE);
    Dout = (k >= 0 && k < N) ? regs[k] : '0;
  end

  // Memory responder: acks after dly_n waiting cycles at address dly_addr, else at once
  always @(negedge clk) begin
    if (mem_req) begin
      if (wcnt == 0) begin
        f_addr = mem_addr; f_wdata = mem_wdata; f_we = mem_we;
      end else if (f_addr != mem_addr || f_wdata != mem_wdata || f_we != mem_we) begin
        unstable++;
      end
      if (wcnt >= ((int'(mem_addr) == dly_addr) ? dly_n : 0)) begin
        mem_ack = 1'b1;
        if (mem_we) begin mem[mem_addr] = mem_wdata; n_wr++; end
        else begin mem_rdata = mem[mem_addr]; n_rd++; end
      end else begin
        mem_ack = 1'b0;
      end
      wcnt++;
    end else begin
      mem_ack = 1'b0;
      wcnt = 0;
    end
  end

  always @(negedge clk) begin
    if (wren) begin wq_adr.push_back(Adr); wq_din.push_back(Din); end
    if (ss_load) begin
      n_load++;
      if (wren || Adr != BASE + 10'(N - 1)) bad_load++;
    end
    if (ss_rst) n_rst++;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clear_mon();
    n_wr = 0; n_rd = 0; n_load = 0; bad_load = 0; n_rst = 0; unstable = 0;
    wq_adr.delete(); wq_din.delete();
  endtask

  function automatic logic [63:0] xsum(input logic [N-1:0][63:0] d);
    logic [63:0] x = '0;
    for (int k = 0; k < N; k++) x ^= d[k];
    return x;
  endfunction

  task automatic do_op(input logic sv, input logic ld, output int nb, output int nd);
    @(negedge clk); start_save = sv; start_load = ld;
    @(negedge clk); start_save = 1'b0; start_load = 1'b0;
    nb = 0; nd = 0;
    for (int k = 0; k < 400; k++) begin
      if (!busy) break;
      nb++;
      if (done) nd++;
      @(negedge clk);
    end
    if (busy) chk("timeout", {63'd0, busy}, 64'd0);
  endtask

  // Slot-level model: save copies mapper slots to memory words, load replays memory words as bus writes
  task automatic run_and_check(input logic is_load, input logic [N-1:0][63:0] d,
                               input int exp_busy, input string tag);
    int nb, nd;
    for (int k = 0; k < 256; k++) mem[k] = '0;
    for (int k = 0; k < N; k++) begin
      if (is_load) mem[k] = d[k];
      else regs[k] = d[k];
    end
    if (is_load) mem[N] = xsum(d);
    clear_mon();
    do_op(!is_load, is_load, nb, nd);
    chk({tag, "_busy"}, 64'(nb), 64'(exp_busy));
    chk({tag, "_done"}, 64'(nd), 64'd1);
    chk({tag, "_stable"}, 64'(unstable), 64'd0);
    chk({tag, "_rst"}, 64'(n_rst), 64'd0);
    chk({tag, "_err"}, {63'd0, error}, 64'd0);
    if (!is_load) begin
      for (int k = 0; k < N; k++) chk({tag, "_memword"}, mem[k], d[k]);
      if (CSW != 0) chk({tag, "_csword"}, mem[N], xsum(d));
      chk({tag, "_nwr"}, 64'(n_wr), 64'(N + CSW));
      chk({tag, "_nrd"}, 64'(n_rd), 64'd0);
      chk({tag, "_nload"}, 64'(n_load), 64'd0);
      chk({tag, "_nwren"}, 64'(wq_adr.size()), 64'd0);
    end else begin
      chk({tag, "_nwren"}, 64'(wq_adr.size()), 64'(N));
      for (int k = 0; k < N && k < wq_adr.size(); k++) begin
        chk({tag, "_wradr"}, 64'(wq_adr[k]), 64'(BASE) + 64'(k));
        chk({tag, "_wrdin"}, wq_din[k], d[k]);
      end
      chk({tag, "_nload"}, 64'(n_load), 64'd1);
      chk({tag, "_loadpos"}, 64'(bad_load), 64'd0);
      chk({tag, "_nwr"}, 64'(n_wr), 64'd0);
    end
  endtask

  typedef struct packed {
    logic                   is_load;
    logic [N-1:0][63:0]     d;
    logic [7:0]             dslot;
    logic [7:0]             dcyc;
    logic [7:0]             exp_busy;
  } vec_t;

  initial begin
    vec_t vt [4];
    logic [N-1:0][63:0] rd;
    int nb, nd, t;

    vt[0] = '{1'b0, {64'h44, 64'h33, 64'h22, 64'h11}, 8'hff, 8'd0, 8'(13 + CS)};
    vt[1] = '{1'b0, {64'hdead_0004, 64'hbeef_0003, 64'hcafe_0002, 64'hf00d_0001}, 8'd2, 8'd5, 8'(18 + CS)};
    vt[2] = '{1'b1, {64'hD, 64'hC, 64'hB, 64'hA}, 8'hff, 8'd0, 8'(10 + CS)};
    vt[3] = '{1'b1, {64'h1234_5678_9abc_def0, 64'h0, 64'hffff_ffff_ffff_ffff, 64'h5}, 8'd1, 8'd3, 8'(13 + CS)};

    for (int k = 0; k < N; k++) regs[k] = '0;
    repeat (3) @(negedge clk);
    chk("reset_ctrl", {56'd0, busy, done, error, wren, ss_rst, ss_load, mem_we, mem_req}, 64'd0);
    chk("reset_adr", 64'(Adr), 64'd0);
    chk("reset_din", Din, 64'd0);
    chk("reset_maddr", 64'(mem_addr), 64'd0);
    chk("reset_wdata", mem_wdata, 64'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      dly_addr = (vt[i].dslot == 8'hff) ? -1 : int'(vt[i].dslot);
      dly_n = int'(vt[i].dcyc);
      run_and_check(vt[i].is_load, vt[i].d, int'(vt[i].exp_busy), $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 12; i++) begin
      logic ld;
      for (int k = 0; k < N; k++) rd[k] = {$urandom, $urandom};
      ld = 1'($urandom_range(0, 1));
      dly_addr = int'($urandom_range(0, N - 1));
      dly_n = int'($urandom_range(0, 6));
      t = ld ? (2 * N + 2 + CS + dly_n) : (3 * N + 1 + CS + dly_n);
      run_and_check(ld, rd, t, $sformatf("rnd%0d", i));
    end
    dly_addr = -1; dly_n = 0;

    // Both starts together: save wins
    clear_mon();
    do_op(1'b1, 1'b1, nb, nd);
    chk("both_nrd", 64'(n_rd), 64'd0);
    chk("both_nwr", 64'(n_wr), 64'(N + CSW));
    chk("both_busy", 64'(nb), 64'(3 * N + 1 + CS));

    // start_load pulsed mid-save is dropped, not queued
    clear_mon();
    @(negedge clk); start_save = 1'b1;
    @(negedge clk); start_save = 1'b0;
    repeat (4) @(negedge clk);
    start_load = 1'b1;
    @(negedge clk); start_load = 1'b0;
    for (int k = 0; k < 100 && busy; k++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("midload_nrd", 64'(n_rd), 64'd0);
    chk("midload_idle", {63'd0, busy}, 64'd0);

    // Reset while slot 1 is waiting for its memory read
    for (int k = 0; k < N; k++) mem[k] = 64'h100 + 64'(k);
    dly_addr = 1; dly_n = 8;
    clear_mon();
    @(negedge clk); start_load = 1'b1;
    @(negedge clk); start_load = 1'b0;
    for (int k = 0; k < 50 && !(mem_req && mem_addr == 8'd1); k++) @(negedge clk);
    chk("rst_reached", {63'd0, mem_req && mem_addr == 8'd1}, 64'd1);
    reset_n = 1'b0;
    @(negedge clk);
    chk("midrst_ctrl", {56'd0, busy, done, error, wren, ss_rst, ss_load, mem_we, mem_req}, 64'd0);
    chk("midrst_adr", 64'(Adr), 64'd0);
    chk("midrst_din", Din, 64'd0);
    chk("midrst_maddr", 64'(mem_addr), 64'd0);
    reset_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("midrst_nwren", 64'(wq_adr.size()), 64'd1);
    chk("midrst_nload", 64'(n_load), 64'd0);
    chk("midrst_idle", {63'd0, busy}, 64'd0);
    dly_addr = -1; dly_n = 0;

`ifdef SS_CHECKSUM_EN
    for (int k = 0; k < N; k++) rd[k] = {$urandom, $urandom};
    run_and_check(1'b0, rd, 3 * N + 1 + CS, "cs_save");
    mem[N] = mem[N] ^ 64'h1;
    clear_mon();
    do_op(1'b0, 1'b1, nb, nd);
    chk("cs_bad_err", {63'd0, error}, 64'd1);
    chk("cs_bad_nload", 64'(n_load), 64'd0);
    chk("cs_bad_done", 64'(nd), 64'd1);
    chk("cs_bad_busy", 64'(nb), 64'(2 * N + CS + 1));
    run_and_check(1'b0, rd, 3 * N + 1 + CS, "cs_resave");
    run_and_check(1'b1, rd, 2 * N + 2 + CS, "cs_reload");
`else
    chk("noc_err", {63'd0, error}, 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
